// File: rtl/mbldcm_phase_sequencer.sv
// Open-loop BLDC commutation sequencer: steps phase 0..5 every
// P*(S+1) clocks, with step and revolution strobes.
module mbldcm_phase_sequencer #(
  parameter int pPeriodWidth   = 16,
  parameter int pPrescaleWidth = 8
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iEnable,
  input  logic                      iDirection,
  input  logic [pPeriodWidth-1:0]   iPeriod,
  input  logic [pPrescaleWidth-1:0] iPrescale,
  input  logic                      iPhaseLoad,
  input  logic [2:0]                iPhaseInit,
  output logic [2:0]                oPhase,
  output logic                      oStep,
  output logic                      oRevolution,
  output logic                      oRunning
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [pPeriodWidth-1:0]   PONE = 1;
  localparam logic [pPeriodWidth-1:0]   PZRO = '0;
  localparam logic [pPrescaleWidth-1:0] SONE = 1;
  localparam logic [pPrescaleWidth-1:0] SZRO = '0;

  state_t state_q, state_d;

  logic [2:0]                phase_q, phase_d;
  logic                      step_q, step_d;
  logic                      rev_q, rev_d;
  logic [pPrescaleWidth-1:0] pc_q, pc_d;
  logic [pPeriodWidth-1:0]   sc_q, sc_d;
  logic [pPeriodWidth-1:0]   per_q, per_d;
  logic [pPrescaleWidth-1:0] pre_q, pre_d;

  logic                      tick;
  logic                      step_now;
  logic                      wrap;
  logic [2:0]                phase_nx;
  logic [2:0]                init_c;
  logic [pPeriodWidth-1:0]   per_eff;

  assign per_eff  = (iPeriod == PZRO) ? PONE : iPeriod;
  assign init_c   = (iPhaseInit > 3'd5) ? 3'd0 : iPhaseInit;
  assign tick     = (state_q == RUN) && (pc_q == pre_q);
  assign step_now = tick && (sc_q == per_q - PONE);

  // Explicit wrap keeps the phase inside 0..5 without a modulo
  always_comb begin
    phase_nx = phase_q;
    wrap     = 1'b0;
    unique case (1'b1)
      (!iDirection && phase_q >= 3'd5): begin
        phase_nx = 3'd0;
        wrap     = 1'b1;
      end
      (!iDirection && phase_q < 3'd5): begin
        phase_nx = phase_q + 3'd1;
      end
      (iDirection && phase_q == 3'd0): begin
        phase_nx = 3'd5;
        wrap     = 1'b1;
      end
      (iDirection && phase_q != 3'd0): begin
        phase_nx = phase_q - 3'd1;
      end
      default: begin
        phase_nx = phase_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    rev_d   = 1'b0;
    pc_d    = pc_q;
    sc_d    = sc_q;
    per_d   = per_q;
    pre_d   = pre_q;
    unique case (state_q)
      IDLE: begin
        pc_d = SZRO;
        sc_d = PZRO;
        if (iPhaseLoad) begin
          phase_d = init_c;
        end
        if (iEnable) begin
          state_d = RUN;
          per_d   = per_eff;
          pre_d   = iPrescale;
        end
      end
      RUN: begin
        if (tick) begin
          pc_d = SZRO;
          sc_d = step_now ? PZRO : sc_q + PONE;
        end else begin
          pc_d = pc_q + SONE;
        end
        if (step_now) begin
          phase_d = phase_nx;
          step_d  = 1'b1;
          rev_d   = wrap;
          per_d   = per_eff;
          pre_d   = iPrescale;
        end
        // A step landing on the disable cycle still completes
        if (!iEnable) begin
          state_d = IDLE;
          pc_d    = SZRO;
          sc_d    = PZRO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      phase_q <= 3'd0;
      step_q  <= 1'b0;
      rev_q   <= 1'b0;
      pc_q    <= SZRO;
      sc_q    <= PZRO;
      per_q   <= PONE;
      pre_q   <= SZRO;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
    end
  end

  assign oPhase      = phase_q;
  assign oStep       = step_q;
  assign oRevolution = rev_q;
  assign oRunning    = (state_q == RUN);

endmodule

// File: tb/tb_mbldcm_phase_sequencer.sv
// Directed vector bench for the BLDC commutation sequencer.
module tb_mbldcm_phase_sequencer;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEnable;
  logic        iDirection;
  logic [15:0] iPeriod;
  logic [7:0]  iPrescale;
  logic        iPhaseLoad;
  logic [2:0]  iPhaseInit;
  logic [2:0]  oPhase;
  logic        oStep;
  logic        oRevolution;
  logic        oRunning;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        en;
    logic        dir;
    logic [15:0] per;
    logic [7:0]  pre;
    logic        ld;
    logic [2:0]  init;
    logic [2:0]  ph;
    logic        st;
    logic        rv;
    logic        run;
  } vec_t;

  vec_t vecs[$];

  mbldcm_phase_sequencer #(
    .pPeriodWidth  (16),
    .pPrescaleWidth(8)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iEnable    (iEnable),
    .iDirection (iDirection),
    .iPeriod    (iPeriod),
    .iPrescale  (iPrescale),
    .iPhaseLoad (iPhaseLoad),
    .iPhaseInit (iPhaseInit),
    .oPhase     (oPhase),
    .oStep      (oStep),
    .oRevolution(oRevolution),
    .oRunning   (oRunning)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic dir,
                     input logic [15:0] per, input logic [7:0] pre,
                     input logic ld, input logic [2:0] init,
                     input logic [2:0] ph, input logic st,
                     input logic rv, input logic run);
    vec_t v;
    v.en = en; v.dir = dir; v.per = per; v.pre = pre;
    v.ld = ld; v.init = init; v.ph = ph; v.st = st;
    v.rv = rv; v.run = run;
    vecs.push_back(v);
  endtask

  // clocks until the next oStep, -1 if none within the budget
  task automatic measure(output int n);
    n = -1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (oStep) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int rseq[4];
    int n;
    rseq = '{2, 1, 0, 5};

    // forward P=3 S=0; a load attempt while running must be ignored
    for (int i = 0; i <= 18; i++)
      add(1, 0, 16'd3, 8'd0, i == 1, 3'd4, 3'((i / 3) % 6),
          (i % 3 == 0) && (i != 0), i == 18, 1);
    add(0, 0, 16'd3, 8'd0, 0, 3'd0, 3'd0, 0, 0, 0);
    add(0, 0, 16'd3, 8'd0, 1, 3'd2, 3'd2, 0, 0, 0);
    // reverse P=2 S=1 from phase 2: a step every 4 clocks
    for (int i = 0; i <= 12; i++)
      add(1, 1, 16'd2, 8'd1, 0, 3'd0, 3'(rseq[i / 4]),
          (i % 4 == 0) && (i != 0), i == 12, 1);
    add(0, 1, 16'd2, 8'd1, 0, 3'd0, 3'd5, 0, 0, 0);
    // load 6 (clamps to 0) and enable together; period 0 acts as 1
    add(1, 0, 16'd0, 8'd0, 1, 3'd6, 3'd0, 0, 0, 1);
    for (int i = 1; i <= 3; i++)
      add(1, 0, 16'd0, 8'd0, 0, 3'd0, 3'(i), 1, 0, 1);
    add(0, 0, 16'd0, 8'd0, 0, 3'd0, 3'd4, 1, 0, 0);
    add(0, 0, 16'd0, 8'd0, 0, 3'd0, 3'd4, 0, 0, 0);

    iRst = 1'b1; iEnable = 1'b1; iDirection = 1'b0;
    iPeriod = 16'd3; iPrescale = 8'd0;
    iPhaseLoad = 1'b0; iPhaseInit = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_phase", oPhase, 0);
      check("rst_step", oStep, 0);
      check("rst_run", oRunning, 0);
    end
    iRst = 1'b0;

    foreach (vecs[i]) begin
      iEnable    = vecs[i].en;
      iDirection = vecs[i].dir;
      iPeriod    = vecs[i].per;
      iPrescale  = vecs[i].pre;
      iPhaseLoad = vecs[i].ld;
      iPhaseInit = vecs[i].init;
      tick();
      check($sformatf("v%0d_phase", i), oPhase, vecs[i].ph);
      check($sformatf("v%0d_step", i), oStep, vecs[i].st);
      check($sformatf("v%0d_rev", i), oRevolution, vecs[i].rv);
      check($sformatf("v%0d_run", i), oRunning, vecs[i].run);
    end

    // period raised 4 -> 8 mid-step
    iEnable = 1'b1; iDirection = 1'b0;
    iPeriod = 16'd4; iPrescale = 8'd0; iPhaseLoad = 1'b0;
    tick();
    check("pc_run", oRunning, 1);
    tick();
    check("pc_nostep", oStep, 0);
    iPeriod = 16'd8;
    measure(n);
    check("pc_first_gap", n, 3);
    check("pc_first_phase", oPhase, 5);
    measure(n);
    check("pc_second_gap", n, 8);
    check("pc_second_phase", oPhase, 0);
    check("pc_second_rev", oRevolution, 1);

    // disable mid-step, load presets, re-enable
    tick(); tick(); tick();
    iEnable = 1'b0;
    tick();
    check("dis_run", oRunning, 0);
    check("dis_phase", oPhase, 0);
    check("dis_step", oStep, 0);
    iPhaseLoad = 1'b1; iPhaseInit = 3'd3;
    tick();
    check("ld3_phase", oPhase, 3);
    iPhaseInit = 3'd7;
    tick();
    check("ld7_phase", oPhase, 0);
    check("ld7_run", oRunning, 0);
    iPhaseLoad = 1'b0;
    iEnable = 1'b1; iPeriod = 16'd8; iPrescale = 8'd1;
    tick();
    check("re_run", oRunning, 1);
    measure(n);
    check("re_gap", n, 16);
    check("re_phase", oPhase, 1);

    // reset mid-step overrides everything
    tick(); tick();
    iRst = 1'b1;
    tick();
    check("mrst_phase", oPhase, 0);
    check("mrst_run", oRunning, 0);
    check("mrst_step", oStep, 0);
    iRst = 1'b0; iEnable = 1'b0;
    tick();
    check("post_run", oRunning, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
